tpu_job_seq: RTL and testbench



---
 rtl/tpu_pkg.sv | 35 +++
 rtl/tpu_job_seq.sv | 131 +++++++++++++
 tb/tb_tpu_job_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and load address map for the tpuv1 job sequencer.
package tpu_pkg;

  localparam logic [15:0] A_BASE      = 16'h0100;
  localparam logic [15:0] B_BASE      = 16'h0200;
  localparam logic [15:0] C_BASE      = 16'h0300;
  localparam logic [15:0] MATMUL_ADDR = 16'h0400;

  localparam int A_WORDS   = 8;
  localparam int B_WORDS   = 8;
  localparam int C_WORDS   = 16;
  localparam int JOB_WORDS = A_WORDS + B_WORDS + C_WORDS;

  typedef enum logic [2:0] {LOAD, MMUL, WAIT, DRAIN, FIN} state_t;

  // C word k lives at C_BASE + 8k; row r low half precedes its high half.
  function automatic logic [15:0] c_addr(input logic [4:0] k);
    return C_BASE + {8'h00, k, 3'b000};
  endfunction

  // Bus address of job word k: A rows, then B rows, then C init words.
  function automatic logic [15:0] load_addr(input logic [4:0] k);
    logic [4:0] off;
    if (k < 5'(A_WORDS)) begin
      return A_BASE + {8'h00, k, 3'b000};
    end else if (k < 5'(A_WORDS + B_WORDS)) begin
      off = k - 5'(A_WORDS);
      return B_BASE + {8'h00, off, 3'b000};
    end else begin
      off = k - 5'(A_WORDS + B_WORDS);
      return c_addr(off);
    end
  endfunction

endpackage

// File: rtl/tpu_job_seq.sv
// Job sequencer: streams a 32-word job onto the tpuv1 bus, fires MatMul,
// waits out the compute window, then drains 16 C words with backpressure.
module tpu_job_seq
  import tpu_pkg::*;
#(
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = 3 * DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  localparam int WCW = $clog2(WAIT_CYCLES);
  // Index of the last C word: DIM rows, two words per row.
  localparam logic [4:0] C_LAST   = 5'(2 * DIM - 1);
  localparam logic [4:0] JOB_LAST = 5'(JOB_WORDS - 1);

  state_t           state, state_nxt;
  logic [4:0]       k;
  logic [WCW-1:0]   wcnt;
  logic             take, cap, ohs, wait_end;
  logic             rw_nxt;
  logic [15:0]      addr_nxt;
  logic [DATAW-1:0] data_nxt;

  assign take     = in_valid && in_ready;
  assign cap      = (state == DRAIN) && (!out_valid || out_ready);
  assign ohs      = out_valid && out_ready;
  assign wait_end = (state == WAIT) && (wcnt == WCW'(WAIT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (take && k == JOB_LAST) state_nxt = MMUL;
      MMUL:    state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = DRAIN;
      DRAIN:   if (cap && k == C_LAST) state_nxt = FIN;
      FIN:     if (ohs) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Handshake/status outputs and the next bus cycle (idle unless driven)
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state != LOAD) || (k != 5'd0);
    rw_nxt   = 1'b0;
    addr_nxt = 16'h0000;
    data_nxt = '0;
    case (state)
      LOAD: if (take) begin
        rw_nxt   = 1'b1;
        addr_nxt = load_addr(k);
        data_nxt = in_data;
      end
      MMUL: begin
        rw_nxt   = 1'b1;
        addr_nxt = MATMUL_ADDR;
      end
      WAIT:  if (wait_end) addr_nxt = C_BASE;
      // Hold the read address under backpressure so tpu_dataOut stays put.
      DRAIN: if (!cap)            addr_nxt = c_addr(k);
             else if (k != C_LAST) addr_nxt = c_addr(k + 5'd1);
      default: ;
    endcase
  end

  // Bus, counters and the inline output register
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      wcnt       <= '0;
      tpu_r_w    <= 1'b0;
      tpu_addr   <= '0;
      tpu_dataIn <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tpu_r_w    <= rw_nxt;
      tpu_addr   <= ADDRW'(addr_nxt);
      tpu_dataIn <= data_nxt;
      done       <= 1'b0;
      case (state)
        LOAD: if (take) k <= (k == JOB_LAST) ? 5'd0 : k + 5'd1;
        MMUL: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + WCW'(1);
          if (wait_end) k <= '0;
        end
        DRAIN: if (cap) begin
          out_data  <= tpu_dataOut;
          out_valid <= 1'b1;
          out_last  <= (k == C_LAST);
          k         <= k + 5'd1;
        end
        FIN: if (ohs) begin
          done      <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          k         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_seq.sv
// Self-checking bench for tpu_job_seq with a behavioural tpuv1 stand-in.
module tb_tpu_job_seq;

  typedef logic [63:0] job_t [32];
  typedef logic [63:0] res_t [16];
  typedef struct { logic [15:0] a; logic [63:0] d; } wr_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b1, out_last, busy, done;
  logic [63:0] out_data;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn, tpu_dataOut;

  int nvec = 0, nerr = 0;

  tpu_job_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr),
    .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // C[i][j] += sum A[i][m]*B[m][j]; A,B bytes, C 16-bit lanes, row r = words 2r (j0..3), 2r+1 (j4..7)
  function automatic void matmul(input job_t w, output res_t r);
    logic [15:0] acc;
    for (int i = 0; i < 8; i++) begin
      r[2*i] = '0; r[2*i+1] = '0;
      for (int j = 0; j < 8; j++) begin
        acc = w[16 + 2*i + j/4][16*(j%4) +: 16];
        for (int m = 0; m < 8; m++)
          acc = acc + 16'(w[i][8*m +: 8]) * 16'(w[8+m][8*j +: 8]);
        r[2*i + j/4][16*(j%4) +: 16] = acc;
      end
    end
  endfunction

  function automatic logic [15:0] exp_addr(input int k);
    if (k < 8)  return 16'(32'h100 + 8*k);
    if (k < 16) return 16'(32'h200 + 8*(k-8));
    return 16'(32'h300 + 8*(k-16));
  endfunction

  // ---- tpuv1 stand-in: stores writes, computes on MatMul, results valid after 3*DIM-2 cycles
  job_t mem;
  res_t cres;
  bit   mm_ok = 0;
  int   mm_at = 0, cyc = 0;

  always @(negedge clk) cyc++;

  always @(posedge clk) begin
    if (rst) mm_ok = 0;
    else if (tpu_r_w) begin
      if (tpu_addr == 16'h0400) begin
        matmul(mem, cres); mm_ok = 1; mm_at = cyc;
      end else if (tpu_addr[2:0] == 3'b0 && tpu_addr[11:8] >= 4'd1 && tpu_addr[11:8] <= 4'd3
                   && tpu_addr[15:12] == 4'd0) begin
        if (tpu_addr[11:8] == 4'd3) mem[16 + tpu_addr[7:3]] = tpu_dataIn;
        else if (tpu_addr[7:6] == 2'b0)
          mem[(tpu_addr[11:8] == 4'd1 ? 0 : 8) + tpu_addr[5:3]] = tpu_dataIn;
      end
    end
  end

  always_comb begin
    tpu_dataOut = 64'hBAD0_BAD0_BAD0_BAD0;
    if (mm_ok && (cyc - mm_at) >= 22 && tpu_addr >= 16'h0300 && tpu_addr <= 16'h0378
        && tpu_addr[2:0] == 3'b0)
      tpu_dataOut = cres[tpu_addr[6:3]];
  end

  // ---- monitor / scoreboard
  wr_t         exp_w[$];
  logic [63:0] exp_out[$];
  bit   exp_rst = 1, acc_prev = 0, last_prev = 0, stall_prev = 0, tb_busy = 0;
  logic [63:0] pv_data;
  logic        pv_last;
  logic [15:0] pv_addr;
  int   nacc = 0, nrw = 0, rx = 0, ndone = 0;

  always @(negedge clk) begin
    wr_t w;
    if (exp_rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_r_w", tpu_r_w, 0);
      chk("rst_addr", tpu_addr, 0);
      chk("rst_dataIn", tpu_dataIn, 0);
      exp_rst = 0;
    end else begin
      chk("done", done, last_prev);
      if (done) ndone++;
      chk("busy", busy, tb_busy);
      if (acc_prev) chk("wr_latency", tpu_r_w, 1);
      if (tpu_r_w) begin
        nrw++;
        if (exp_w.size() == 0) chk("spurious_wr", tpu_addr, 16'hFFFF);
        else begin
          w = exp_w.pop_front();
          chk("wr_addr", tpu_addr, w.a);
          chk("wr_data", tpu_dataIn, w.d);
        end
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pv_data);
        chk("stall_last", out_last, pv_last);
        chk("stall_addr", tpu_addr, pv_addr);
      end
      if (nacc == 32) chk("in_ready_busy", in_ready, 0);
    end
    // sample what the coming edge will do
    if (rst) begin
      exp_rst = 1; acc_prev = 0; last_prev = 0; stall_prev = 0; tb_busy = 0;
      nacc = 0; nrw = 0; rx = 0;
      exp_w.delete(); exp_out.delete();
    end else begin
      acc_prev = in_valid && in_ready;
      if (acc_prev) begin
        exp_w.push_back('{exp_addr(nacc), in_data});
        nacc++;
        if (nacc == 32) exp_w.push_back('{16'h0400, 64'h0});
        tb_busy = 1;
      end
      last_prev = 0;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("spurious_out", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("out_data", out_data, exp_out.pop_front());
        chk("out_last", out_last, rx == 15);
        rx++;
        if (out_last) begin
          chk("rw_count", nrw, 33);
          last_prev = 1; tb_busy = 0; nacc = 0; nrw = 0; rx = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      pv_data = out_data; pv_last = out_last; pv_addr = tpu_addr;
    end
  end

  // ---- driver
  job_t jobs [7];
  int   carry = 0;

  task automatic run_job(input int idx, input bit gappy, input bit bp, input int stall_at,
                         input int rst_wait, input bit b2b);
    int  j, guard, scnt;
    bit  acc, seen;
    res_t r;
    j = carry; carry = 0; guard = 0;
    while (j < 32 && guard < 400) begin
      in_valid  = gappy ? (guard % 2 == 0) : 1'b1;
      in_data   = jobs[idx][j];
      out_ready = 1'b1;
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) j++;
      guard++;
    end
    if (j < 32) chk("feed_timeout", j, 32);
    in_valid = b2b;
    in_data  = b2b ? jobs[idx+1][0] : 64'h0;
    matmul(jobs[idx], r);
    foreach (r[i]) exp_out.push_back(r[i]);
    if (rst_wait >= 0) begin
      repeat (rst_wait + 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      in_valid = 1'b0;
      return;
    end
    scnt = 0; seen = 0; guard = 0;
    while (!seen && guard < 400) begin
      if (stall_at >= 0 && rx == stall_at && scnt < 5) begin
        out_ready = 1'b0; scnt++;
      end else out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (done) seen = 1;
      if (b2b && in_valid && in_ready) carry = 1;
      @(posedge clk); #1;
      guard++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    // job 0: A = identity, B[i][j] = i+j, C = 0
    for (int i = 0; i < 8; i++) begin
      jobs[0][i] = '0; jobs[0][8+i] = '0;
      jobs[0][i][8*i +: 8] = 8'd1;
      for (int c = 0; c < 8; c++) jobs[0][8+i][8*c +: 8] = 8'(i + c);
    end
    for (int i = 16; i < 32; i++) jobs[0][i] = '0;
    for (int n = 1; n < 7; n++)
      for (int i = 0; i < 32; i++) jobs[n][i] = {$urandom, $urandom};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_job(0, 0, 0, -1, -1, 0);   // directed identity job
    run_job(1, 1, 0, -1, -1, 0);   // gappy input
    run_job(2, 0, 0,  6, -1, 0);   // 5-cycle stall at word 6
    run_job(3, 0, 0, -1, 10, 0);   // reset mid WAIT
    run_job(4, 0, 1, -1, -1, 0);   // random backpressure after abort
    run_job(5, 0, 0, -1, -1, 1);   // offer next job during WAIT/DRAIN
    run_job(6, 0, 1, -1, -1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", ndone, 6);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
